// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: mm:ss.cc time base, run/stop/lap FSM and a small lap
// memory that can be stepped through while stopped.
module stopwatch_lap_ctrl #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MIN_MAX   = 99
) (
  input  logic                                               clk_core,
  input  logic                                               rst,
  input  logic                                               pause,
  input  logic                                               record,
  input  logic                                               recall,
  output logic [7:0]                                         min_o,
  output logic [7:0]                                         sec_o,
  output logic [7:0]                                         ms_10_o,
  output logic                                               running,
  output logic                                               frozen,
  output logic [$clog2(LAP_DEPTH+1)-1:0]                     lap_cnt,
  output logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] lap_idx,
  output logic                                               lap_full
);

  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int PSC_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_STOP,
    S_RECALL
  } state_t;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } time_t;

  state_t             state_q, state_d;
  logic [PSC_W-1:0]   presc_q;
  time_t              live_q, live_inc, snap_q, disp;
  time_t              lap_mem [LAP_DEPTH];
  logic [CNT_W-1:0]   lap_cnt_q;
  logic [IDX_W-1:0]   lap_idx_q;

  // Priority decode: pause beats record beats recall; losers are dropped.
  logic ev_pause, ev_record, ev_recall;
  assign ev_pause  = pause;
  assign ev_record = record & ~pause;
  assign ev_recall = recall & ~pause & ~record;

  logic counting, full, tick;
  logic do_lap, do_store, do_clear, do_enter, do_step, idx_last;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign full     = (lap_cnt_q == CNT_W'(LAP_DEPTH));
  assign tick     = counting && (presc_q == PSC_W'(TICK_DIV - 1));

  assign do_lap   = counting && ev_record;
  assign do_store = do_lap && !full;
  assign do_clear = ((state_q == S_STOP) || (state_q == S_RECALL)) && ev_record;
  assign do_enter = (state_q == S_STOP) && ev_recall && (lap_cnt_q != '0);
  assign do_step  = (state_q == S_RECALL) && ev_recall;
  assign idx_last = (CNT_W'(lap_idx_q) == (lap_cnt_q - CNT_W'(1)));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d; no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ev_pause) state_d = S_RUN;
      end
      S_RUN, S_LAP: begin
        if (ev_pause)       state_d = S_STOP;
        else if (ev_record) state_d = S_LAP;
      end
      S_STOP: begin
        if (ev_pause)       state_d = S_RUN;
        else if (ev_record) state_d = S_IDLE;
        else if (do_enter)  state_d = S_RECALL;
      end
      S_RECALL: begin
        if (ev_pause)       state_d = S_STOP;
        else if (ev_record) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    disp     = live_q;
    running  = counting;
    frozen   = (state_q == S_LAP) || (state_q == S_RECALL);
    lap_idx  = '0;
    lap_cnt  = lap_cnt_q;
    lap_full = full;
    if (state_q == S_LAP) begin
      disp = snap_q;
    end else if (state_q == S_RECALL) begin
      disp    = lap_mem[lap_idx_q];
      lap_idx = lap_idx_q;
    end
    min_o   = disp.min;
    sec_o   = disp.sec;
    ms_10_o = disp.cs;
  end

  // ---------------------------------------------------------- time base
  always_comb begin
    live_inc = live_q;
    if (live_q.cs == 8'd99) begin
      live_inc.cs = '0;
      if (live_q.sec == 8'd59) begin
        live_inc.sec = '0;
        live_inc.min = (live_q.min == 8'(MIN_MAX)) ? 8'd0 : live_q.min + 8'd1;
      end else begin
        live_inc.sec = live_q.sec + 8'd1;
      end
    end else begin
      live_inc.cs = live_q.cs + 8'd1;
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is updated with <= so every flop samples
      // pre-edge values; a lap capture therefore sees the untick'd time.
      presc_q <= '0;
      live_q  <= '0;
    end else if (do_clear) begin
      presc_q <= '0;
      live_q  <= '0;
    end else if (counting) begin
      presc_q <= tick ? '0 : presc_q + PSC_W'(1);
      if (tick) live_q <= live_inc;
    end
  end

  // -------------------------------------------------------- lap storage
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      snap_q    <= '0;
      lap_cnt_q <= '0;
      // NOTE: the lap memory is tiny and must read back as zero after reset,
      // so it is built from resettable flops rather than an SRAM macro.
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem[i] <= '0;
    end else begin
      if (do_lap) snap_q <= live_q;
      if (do_store) begin
        lap_mem[lap_cnt_q[IDX_W-1:0]] <= live_q;
        lap_cnt_q                     <= lap_cnt_q + CNT_W'(1);
      end else if (do_clear) begin
        lap_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst)                    lap_idx_q <= '0;
    else if (do_clear || do_enter) lap_idx_q <= '0;
    else if (do_step)            lap_idx_q <= idx_last ? '0 : lap_idx_q + IDX_W'(1);
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl at TICK_DIV=2, LAP_DEPTH=2, MIN_MAX=1.
module tb_stopwatch_lap_ctrl;

  localparam int TD = 2;
  localparam int LD = 2;
  localparam int MM = 1;

  logic       clk_core = 1'b0;
  logic       rst;
  logic       pause, record, recall;
  logic [7:0] min_o, sec_o, ms_10_o;
  logic       running, frozen, lap_full;
  logic [1:0] lap_cnt;
  logic [0:0] lap_idx;

  int passed = 0;
  int total  = 0;

  stopwatch_lap_ctrl #(.TICK_DIV(TD), .LAP_DEPTH(LD), .MIN_MAX(MM)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .pause    (pause),
    .record   (record),
    .recall   (recall),
    .min_o    (min_o),
    .sec_o    (sec_o),
    .ms_10_o  (ms_10_o),
    .running  (running),
    .frozen   (frozen),
    .lap_cnt  (lap_cnt),
    .lap_idx  (lap_idx),
    .lap_full (lap_full)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic p, r, c;
    int   w;
    int   m, s, cs;
    int   run, frz, cnt, idx;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int m, input int s, input int cs,
                           input int run, input int frz, input int cnt, input int idx);
    check({tag, "_min"},  int'(min_o),    m);
    check({tag, "_sec"},  int'(sec_o),    s);
    check({tag, "_cs"},   int'(ms_10_o),  cs);
    check({tag, "_run"},  int'(running),  run);
    check({tag, "_frz"},  int'(frozen),   frz);
    check({tag, "_cnt"},  int'(lap_cnt),  cnt);
    check({tag, "_idx"},  int'(lap_idx),  idx);
    check({tag, "_full"}, int'(lap_full), (cnt == LD) ? 1 : 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  // Called at a negedge; the pulse is sampled by the following rising edge.
  task automatic pulse(input logic p, input logic r, input logic c);
    pause = p; record = r; recall = c;
    @(negedge clk_core);
    pause = 1'b0; record = 1'b0; recall = 1'b0;
  endtask

  vec_t vecs [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Starts in RUN at 00:00.01 with the prescaler just wrapped.
    vecs[0]  = '{1'b1, 1'b1, 1'b0,  0, 0, 0,  1, 0, 0, 0, 0}; // pause+record: STOP
    vecs[1]  = '{1'b0, 1'b1, 1'b0,  0, 0, 0,  0, 0, 0, 0, 0}; // clear -> IDLE
    vecs[2]  = '{1'b0, 1'b0, 1'b1,  0, 0, 0,  0, 0, 0, 0, 0}; // recall in IDLE ignored
    vecs[3]  = '{1'b0, 1'b1, 1'b0,  0, 0, 0,  0, 0, 0, 0, 0}; // record in IDLE ignored
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 20, 0, 0, 10, 1, 0, 0, 0}; // run to .10
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 29, 0, 0, 10, 1, 1, 1, 0}; // lap .10
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 29, 0, 0, 25, 1, 1, 2, 0}; // lap .25
    vecs[7]  = '{1'b0, 1'b1, 1'b0,  0, 0, 0, 40, 1, 1, 2, 0}; // full: snapshot only
    vecs[8]  = '{1'b1, 1'b0, 1'b0,  0, 0, 0, 41, 0, 0, 2, 0}; // stop, live shown
    vecs[9]  = '{1'b0, 1'b0, 1'b1,  0, 0, 0, 10, 0, 1, 2, 0}; // recall lap 0
    vecs[10] = '{1'b0, 1'b0, 1'b1,  0, 0, 0, 25, 0, 1, 2, 1}; // recall lap 1
    vecs[11] = '{1'b0, 1'b0, 1'b1,  0, 0, 0, 10, 0, 1, 2, 0}; // wrap to lap 0
    vecs[12] = '{1'b1, 1'b0, 1'b0,  0, 0, 0, 41, 0, 0, 2, 0}; // back to STOP
    vecs[13] = '{1'b1, 1'b0, 1'b0,  0, 0, 0, 41, 1, 0, 2, 0}; // resume, no clear
    vecs[14] = '{1'b0, 1'b0, 1'b1,  1, 0, 0, 42, 1, 0, 2, 0}; // recall in RUN ignored
    vecs[15] = '{1'b0, 1'b1, 1'b0,  0, 0, 0, 42, 1, 1, 2, 0}; // full lap in RUN

    rst = 1'b0; pause = 1'b0; record = 1'b0; recall = 1'b0;
    #3;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    #14 rst = 1'b1;
    @(negedge clk_core);
    check_all("idle", 0, 0, 0, 0, 0, 0, 0);

    // Basic run: 200 cycles at TICK_DIV=2 is 100 ticks.
    pulse(1'b1, 1'b0, 1'b0);
    check_all("start", 0, 0, 0, 1, 0, 0, 0);
    step(200);
    check_all("run200", 0, 1, 0, 1, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    step(50);
    check_all("hold", 0, 1, 0, 0, 0, 0, 0);
    pulse(1'b0, 1'b1, 1'b0);
    check_all("clear", 0, 0, 0, 0, 0, 0, 0);

    // Rollover: 11999 ticks is 01:59.99, one more wraps every field.
    pulse(1'b1, 1'b0, 1'b0);
    step(23998);
    check_all("max", 1, 59, 99, 1, 0, 0, 0);
    step(1);
    check_all("max_hold", 1, 59, 99, 1, 0, 0, 0);
    step(1);
    check_all("wrap", 0, 0, 0, 1, 0, 0, 0);
    step(2);
    check_all("after_wrap", 0, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      pulse(vecs[i].p, vecs[i].r, vecs[i].c);
      step(vecs[i].w);
      check_all($sformatf("v%0d", i), vecs[i].m, vecs[i].s, vecs[i].cs,
                vecs[i].run, vecs[i].frz, vecs[i].cnt, vecs[i].idx);
    end

    // Asynchronous reset in LAP, off the clock edge.
    #3 rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    @(negedge clk_core);
    check_all("post_rst", 0, 0, 0, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("rst_run", 0, 0, 0, 1, 0, 0, 0);
    step(1);
    check_all("first_tick_pre", 0, 0, 0, 1, 0, 0, 0);
    step(1);
    check_all("first_tick", 0, 0, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Parametrised stopwatch controller that succeeds the two-button run/freeze commander. It owns the mm:ss.cc time base, a run/stop/lap state machine and a LAP_DEPTH-entry lap memory that can be recalled while stopped. It sits between the debounced button pulses and the display driver, and feeds binary min/sec/centisecond bytes to the existing digit decoder.

## Interface
- TICK_DIV, default 1000000: clk_core cycles per 10 ms tick; must be ≥ 2.
- LAP_DEPTH, default 4: number of stored laps; must be ≥ 1.
- MIN_MAX, default 99: last minute value before the counter rolls over to 0.
- clk_core  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pause  in  1  single-cycle pulse: start/stop.
- record  in  1  single-cycle pulse: lap when counting, clear when stopped.
- recall  in  1  single-cycle pulse: step through stored laps while stopped.
- min_o  out  8  displayed minutes, binary, 0..MIN_MAX.
- sec_o  out  8  displayed seconds, binary, 0..59.
- ms_10_o  out  8  displayed centiseconds, binary, 0..99.
- running  out  1  high in RUN and LAP.
- frozen  out  1  high when the display shows a stored or snapshot value (LAP, RECALL).
- lap_cnt  out  $clog2(LAP_DEPTH+1)  number of laps stored.
- lap_idx  out  $clog2(LAP_DEPTH) max 1  index being shown in RECALL, otherwise 0.
- lap_full  out  1  lap_cnt == LAP_DEPTH.

## Operation
- States: IDLE (stopped, time zero), RUN, LAP (counting, display frozen), STOP (stopped, time ≠ 0 possible), RECALL.
- Event priority within a cycle: pause > record > recall. Lower-priority pulses in the same cycle are dropped.
- IDLE: pause → RUN. record and recall are ignored.
- RUN: pause → STOP. record writes the live time into lap[lap_cnt], increments lap_cnt, loads the snapshot register, and moves to LAP.
- LAP: counting continues. record stores a new lap and reloads the snapshot, staying in LAP. pause → STOP, and the display returns to live.
- STOP: pause → RUN, which resumes without clearing. record clears the time, prescaler and lap_cnt, then → IDLE. recall with lap_cnt > 0 → RECALL with lap_idx = 0; with lap_cnt = 0 it is ignored.
- RECALL: recall sets lap_idx+1, wrapping to 0 after lap_cnt−1. pause → STOP and does not resume. record clears as in STOP, then → IDLE.
- Full memory: a record in RUN/LAP while lap_full is set still loads the snapshot and enters/stays in LAP. The memory and lap_cnt are unchanged.
- Time base: the prescaler counts 0..TICK_DIV−1 only while running and holds its value in STOP/RECALL. Each wrap is one tick.
- Tick carry chain: ms_10 counts 99→0 and carries into sec; sec counts 59→0 and carries into min; min counts MIN_MAX→0. At MIN_MAX:59.99 plus one tick, all three fields are 0 and counting continues.
- Display mux: live counter in IDLE/RUN/STOP, snapshot in LAP, lap[lap_idx] in RECALL.

## Timing
- Reset, asynchronous: state IDLE; all counters, snapshot, lap memory, lap_cnt and lap_idx are 0. All outputs are 0.
- A pulse sampled at edge t changes state at edge t. The new state and outputs are valid in cycle t+1.
- Outputs are combinational from registered state, counters and memory; there are no further output registers.
- Lap capture takes the counter value held before edge t. A tick at the same edge is applied to the live counter only.
- First tick after IDLE→RUN arrives TICK_DIV cycles after the pause edge.
- Reset asserted mid-run aborts immediately. Laps are not retained.

## Test plan
- Basic run with TICK_DIV=2, MIN_MAX=1: pause, then run 200 cycles → 00:01.00, running=1. Pause again → time holds for 50 cycles.
- Rollover with TICK_DIV=2, MIN_MAX=1: run to 01:59.99, apply one more tick → 00:00.00 and counting continues.
- Laps with LAP_DEPTH=2: record at 00:00.10, 00:00.25, 00:00.40 → lap_cnt=2, lap_full=1. The third record updates the display to 00:00.40, and the memory still holds .10 and .25.
- Recall: stop, then press recall three times → displays .10, .25, .10 with lap_idx 0, 1, 0. Pause → live time, state STOP, running=0.
- Priority: pause and record in the same cycle in RUN → STOP, lap_cnt unchanged. record in STOP → all zero, IDLE. recall in IDLE → no change.
- Asynchronous reset mid-LAP, not aligned to clk_core → outputs 0 immediately. lap_cnt=0 and state IDLE after release.
